// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback.
// Optional macro BNE_EN adds a bne execute state (BNEEX) and the matching pcen term.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  output logic               pcen,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    RTYPEEX = STATE_W'(6),
    RTYPEWB = STATE_W'(7),
    BEQEX   = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JEX     = STATE_W'(11),
    BNEEX   = STATE_W'(12)
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t state_q;
  state_t state_n;
  logic   pcwrite;
  logic   branch;
`ifdef BNE_EN
  logic   bne;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = FETCH;
    case (state_q)
      FETCH:  state_n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE:     state_n = RTYPEEX;
          OP_BEQ:       state_n = BEQEX;
          OP_ADDI:      state_n = ADDIEX;
          OP_J:         state_n = JEX;
`ifdef BNE_EN
          OP_BNE:       state_n = BNEEX;
`endif
          default:      state_n = FETCH;
        endcase
      end
      MEMADR:  state_n = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_n = MEMWB;
      RTYPEEX: state_n = RTYPEWB;
      ADDIEX:  state_n = ADDIWB;
      default: state_n = FETCH;
    endcase
  end

  // Moore decode of the state register; reset overrides with FETCH values and no writes.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
`ifdef BNE_EN
    bne      = 1'b0;
`endif
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    case (state_q)
      FETCH:   begin irwrite = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
      DECODE:  alusrcb = 2'b11;
      MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin regwrite = 1'b1; memtoreg = 1'b1; end
      MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
      RTYPEWB: begin regdst = 1'b1; regwrite = 1'b1; end
      BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; branch = 1'b1; pcsrc = 2'b01; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      ADDIWB:  regwrite = 1'b1;
      JEX:     begin pcwrite = 1'b1; pcsrc = 2'b10; end
`ifdef BNE_EN
      BNEEX:   begin alusrca = 1'b1; aluop = 2'b01; bne = 1'b1; pcsrc = 2'b01; end
`endif
      default: ;
    endcase
    if (reset) begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
`ifdef BNE_EN
      bne      = 1'b0;
`endif
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b01;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
    end
`ifdef BNE_EN
    pcen = pcwrite | (branch & zero) | (bne & ~zero);
`else
    pcen = pcwrite | (branch & zero);
`endif
  end

  assign state = reset ? '0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, reset corner case and random instruction stream.
// Honors BNE_EN the same way as the design.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .state(state)
  );

  always #5 clk = ~clk;

  logic [13:0] outs;
  assign outs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, aluop};

  // Output bundle layout: {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluop}
  function automatic logic [13:0] pack(input logic pe, io, mw, iw, rd, mt, rw, sa,
                                       input logic [1:0] sb, ps, ao);
    return {pe, io, mw, iw, rd, mt, rw, sa, sb, ps, ao};
  endfunction

  // Per-state assertion list from the control table.
  function automatic logic [13:0] exp_out(input int st, input logic z);
    case (st)
      0:  return pack(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      1:  return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
      2:  return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      3:  return pack(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      4:  return pack(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
      5:  return pack(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      6:  return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10);
      7:  return pack(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      8:  return pack(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
      9:  return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      10: return pack(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      11: return pack(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00);
`ifdef BNE_EN
      12: return pack(~z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
`endif
      default: return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    endcase
  endfunction

  function automatic logic [13:0] exp_reset();
    return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
  endfunction

  // Instruction walk as a list of visited states, one nibble per cycle starting at FETCH.
  function automatic void path(input logic [5:0] o, output int n, output logic [23:0] seq);
    case (o)
      6'b100011: begin n = 5; seq = 24'h043210; end
      6'b101011: begin n = 4; seq = 24'h005210; end
      6'b000000: begin n = 4; seq = 24'h007610; end
      6'b000100: begin n = 3; seq = 24'h000810; end
      6'b001000: begin n = 4; seq = 24'h00A910; end
      6'b000010: begin n = 3; seq = 24'h000B10; end
`ifdef BNE_EN
      6'b000101: begin n = 3; seq = 24'h000C10; end
`endif
      default:   begin n = 2; seq = 24'h000010; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in FETCH; leaves it at a negedge back in FETCH.
  // zsel: 0/1 fixed zero flag, 2 random each cycle.
  task automatic run_instr(input string tag, input logic [5:0] o, input int zsel,
                           input int n, input logic [23:0] seq);
    op = o;
    for (int c = 0; c < n; c++) begin
      zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
      #1;
      chk($sformatf("%s c%0d state", tag, c), 32'(state), 32'(seq[4*c +: 4]));
      chk($sformatf("%s c%0d outs", tag, c), 32'(outs), 32'(exp_out(int'(seq[4*c +: 4]), zero)));
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk($sformatf("%s return", tag), 32'(state), 32'd0);
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    int         zsel;
    int         len;
    logic [23:0] seq;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int          n;
    logic [23:0] seq;
    logic [5:0]  o;
    int          guard;

    reset = 1'b1;
    op    = 6'b000000;
    zero  = 1'b0;

    tbl.push_back('{"lw",      6'b100011, 0, 5, 24'h043210});
    tbl.push_back('{"sw",      6'b101011, 0, 4, 24'h005210});
    tbl.push_back('{"rtype",   6'b000000, 1, 4, 24'h007610});
    tbl.push_back('{"beq_z1",  6'b000100, 1, 3, 24'h000810});
    tbl.push_back('{"beq_z0",  6'b000100, 0, 3, 24'h000810});
    tbl.push_back('{"addi",    6'b001000, 0, 4, 24'h00A910});
    tbl.push_back('{"j",       6'b000010, 0, 3, 24'h000B10});
    tbl.push_back('{"unk3f",   6'b111111, 1, 2, 24'h000010});
`ifdef BNE_EN
    tbl.push_back('{"bne_z0",  6'b000101, 0, 3, 24'h000C10});
    tbl.push_back('{"bne_z1",  6'b000101, 1, 3, 24'h000C10});
`else
    tbl.push_back('{"bne_off", 6'b000101, 0, 2, 24'h000010});
`endif

    @(negedge clk);
    #1;
    chk("rst0 state", 32'(state), 32'd0);
    chk("rst0 outs", 32'(outs), 32'(exp_reset()));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) run_instr(tbl[i].name, tbl[i].op, tbl[i].zsel, tbl[i].len, tbl[i].seq);

    // Reset held two clocks in the middle of an R-type instruction.
    op = 6'b000000;
    guard = 0;
    while (state !== 4'd6 && guard < 10) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      guard++;
    end
    chk("reach rtypeex", 32'(state), 32'd6);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("midrst c%0d state", c), 32'(state), 32'd0);
      chk($sformatf("midrst c%0d outs", c), 32'(outs), 32'(exp_reset()));
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("post rst state", 32'(state), 32'd0);
    chk("post rst irwrite", 32'(irwrite), 32'd1);
    chk("post rst pcen", 32'(pcen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("post rst decode", 32'(state), 32'd1);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("post rst return", 32'(state), 32'd0);

    // Random instruction stream against the path/state-table model.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 8))
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: o = 6'b000000;
        3: o = 6'b000100;
        4: o = 6'b001000;
        5: o = 6'b000010;
        6: o = 6'b000101;
        default: o = 6'($urandom_range(0, 63));
      endcase
      path(o, n, seq);
      run_instr($sformatf("rnd%0d op%02h", k, o), o, 2, n, seq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
